// File: rtl/spram_pkg.sv
// Shared sizing constants and lane-merge helper for the 8K x 32 byte-enable RAM.
package spram_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = 4;
    localparam int BYTE_SIZE  = 8;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    // Lanes with be[i]=1 take new_word, the rest keep old_word.
    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                merged[i*BYTE_SIZE +: BYTE_SIZE] = new_word[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/spram_8kx32_be.sv
// Single-port 8K x 32 RAM with per-byte write enables and a transparent,
// one-cycle registered read port.
module spram_8kx32_be
    import spram_pkg::*;
(
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Array is deliberately unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!tb_rst && wr_en) begin
            mem[addr] <= byte_merge(mem[addr], wr_data, wr_byte_en);
        end
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_q <= '0;
        end else if (wr_en) begin
            rd_q <= byte_merge(mem[addr], wr_data, wr_byte_en);
        end else begin
            rd_q <= mem[addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: tb/tb_spram_8kx32_be.sv
// Scoreboard bench for spram_8kx32_be: driver queues expected read words from
// a word-array reference model, a monitor compares them one cycle later.
module tb_spram_8kx32_be;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NW = 8192;

    logic          clk;
    logic          tb_rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic [BW-1:0] wr_byte_en;
    logic [DW-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [NW];
    logic [DW-1:0] exp_q [$];
    string         tag_q [$];

    spram_8kx32_be dut (
        .clk        (clk),
        .tb_rst     (tb_rst),
        .addr       (addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .wr_byte_en (wr_byte_en),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: rd_data=%08h required=%08h at %0t", name, got, want, $time);
        end
    endtask

    // One access per cycle; the expected word is what the model says the
    // output register must hold after the coming rising edge.
    task automatic op(input string name, input int a, input logic we,
                      input logic [DW-1:0] d, input logic [BW-1:0] be);
        logic [DW-1:0] want;
        @(negedge clk);
        addr       = AW'(a);
        wr_en      = we;
        wr_data    = d;
        wr_byte_en = be;
        if (we) begin
            for (int i = 0; i < BW; i++)
                if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end
        want = model[a];
        exp_q.push_back(want);
        tag_q.push_back(name);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), rd_data, exp_q.pop_front());
        end
    end

    initial begin
        tb_rst     = 1'b1;
        addr       = '0;
        wr_en      = 1'b0;
        wr_data    = '0;
        wr_byte_en = '0;

        for (int t = 0; t < 10; t++) begin
            #20;
            check("reset_hold", rd_data, 32'h0);
        end
        @(negedge clk);
        tb_rst = 1'b0;

        for (int k = 1; k < NW; k++)
            op("full_write", k, 1'b1, 32'hFFFF_FFFF - DW'(k - 1), 4'hF);
        op("full_write", 0, 1'b1, 32'hFFFF_E000, 4'hF);

        for (int k = 1; k < NW; k++)
            op("full_read", k, 1'b0, 32'h0, 4'h0);
        op("full_read", 0, 1'b0, 32'h0, 4'h0);

        op("be_full", 5, 1'b1, 32'h1122_3344, 4'hF);
        op("be_partial", 5, 1'b1, 32'hAABB_CCDD, 4'b0101);
        op("be_read", 5, 1'b0, 32'h0, 4'h0);
        op("be_none", 5, 1'b1, 32'h5566_7788, 4'h0);
        op("be_none_read", 5, 1'b0, 32'h0, 4'h0);

        op("pre_rst_read", 10, 1'b0, 32'h0, 4'h0);
        @(posedge clk);
        #2 tb_rst = 1'b1;
        #1 check("async_rst", rd_data, 32'h0);
        #1 tb_rst = 1'b0;
        op("post_rst_read1", 1, 1'b0, 32'h0, 4'h0);
        op("post_rst_read2", 2, 1'b0, 32'h0, 4'h0);

        @(negedge clk);
        tb_rst     = 1'b1;
        addr       = AW'(7);
        wr_en      = 1'b1;
        wr_data    = 32'hDEAD_BEEF;
        wr_byte_en = 4'hF;
        @(posedge clk);
        #1 check("write_in_rst", rd_data, 32'h0);
        @(negedge clk);
        tb_rst = 1'b0;
        wr_en  = 1'b0;
        op("read_after_rst_write", 7, 1'b0, 32'h0, 4'h0);

        for (int n = 0; n < 400; n++) begin
            int a;
            a = (n % 2 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(NW - 16, NW - 1));
            op("random", a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        end
        op("wrap_hi", NW - 1, 1'b0, 32'h0, 4'h0);
        op("wrap_lo", 0, 1'b0, 32'h0, 4'h0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
